cpu_sram_responder: RTL

// - Responder side of the core's sram-like instruction and data ports: decodes core requests, answers them from one unified on-chip memory.
// - Drop-in target for bench and FPGA bring-up; sits directly below the core, with no bus fabric between them.
// - Fixed 1-cycle read latency: the core has no wait/ready input, so the block never stalls.

---
 rtl/cpu_sram_responder_pkg.sv | 38 +++
 rtl/cpu_sram_responder_sram_bank_2r1w.sv | 67 ++++++
 rtl/cpu_sram_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_sram_responder_pkg.sv
// ============================================================================
// Module : cpu_sram_responder_pkg
// Brief  : Shared constants, access-kind encoding and lane-merge helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_sram_responder_pkg;

   localparam int                C_SRAM_AW   = 14;
   localparam logic [31:0]       C_SRAM_BASE = 32'h1FC0_0000;
   localparam logic [31:0]       C_SRAM_MASK = 32'h0000_FFFF;
   localparam int                C_ERR_CNT_W = 16;
   localparam logic [C_ERR_CNT_W-1:0] C_ERR_CNT_MAX = '1;

   typedef enum logic [1:0] {
      ACC_IDLE  = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2,
      ACC_BAD   = 2'd3
   } acc_kind_t;

   function automatic logic [31:0] merge_lanes(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  wen
   );
      logic [31:0] res;
      res = old_word;
      for (int k = 0; k < 4; k++) begin
         if (wen[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_sram_responder_sram_bank_2r1w.sv
// ============================================================================
// Module : sram_bank_2r1w
// Brief  : 2**AW x 32 array, one byte-lane write port, two registered
//          write-first read ports with load/clear control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_bank_2r1w
   import cpu_sram_responder_pkg::*;
#(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic          i_a_load,
   input  logic          i_a_clr,
   input  logic [AW-1:0] i_a_addr,
   output logic [31:0]   o_a_q,
   input  logic          i_b_load,
   input  logic          i_b_clr,
   input  logic [AW-1:0] i_b_addr,
   output logic [31:0]   o_b_q
);

   logic [31:0] r_mem [2**AW];
   logic [31:0] r_a_q;
   logic [31:0] r_b_q;
   logic [31:0] w_a_word;
   logic [31:0] w_b_word;
   logic        w_wr;

   assign w_wr = |i_we;

   // A read that hits the word being written sees the merged new value.
   always_comb begin
      w_a_word = r_mem[i_a_addr];
      w_b_word = r_mem[i_b_addr];
      if (w_wr && (i_waddr == i_a_addr)) w_a_word = merge_lanes(w_a_word, i_wdata, i_we);
      if (w_wr && (i_waddr == i_b_addr)) w_b_word = merge_lanes(w_b_word, i_wdata, i_we);
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[i_waddr] <= merge_lanes(r_mem[i_waddr], i_wdata, i_we);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a_q <= '0;
         r_b_q <= '0;
      end else begin
         if (i_a_clr)       r_a_q <= '0;
         else if (i_a_load) r_a_q <= w_a_word;
         if (i_b_clr)       r_b_q <= '0;
         else if (i_b_load) r_b_q <= w_b_word;
      end
   end

   assign o_a_q = r_a_q;
   assign o_b_q = r_b_q;

endmodule

`default_nettype wire

// File: rtl/cpu_sram_responder.sv
// ============================================================================
// Module : cpu_sram_responder
// Brief  : Answers the core's inst/data sram-like ports from one on-chip
//          memory with fixed 1-cycle latency; counts and captures bad accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_sram_responder
   import cpu_sram_responder_pkg::*;
#(
   parameter int          AW   = C_SRAM_AW,
   parameter logic [31:0] BASE = C_SRAM_BASE,
   parameter logic [31:0] MASK = C_SRAM_MASK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] err_cnt,
   output logic [31:0] err_addr,
   output logic        err_valid
);

   logic [31:0]              w_inst_off;
   logic [31:0]              w_data_off;
   logic                     w_inst_hit;
   logic                     w_data_hit;
   logic [AW-1:0]            w_inst_idx;
   logic [AW-1:0]            w_data_idx;
   acc_kind_t                w_data_kind;
   logic                     w_inst_err;
   logic                     w_data_err;
   logic [3:0]               w_we;
   logic [1:0]               w_err_inc;
   logic [C_ERR_CNT_W:0]     w_err_sum;
   logic [C_ERR_CNT_W-1:0]   w_err_next;
   logic [C_ERR_CNT_W-1:0]   r_err_cnt;
   logic [31:0]              r_err_addr;
   logic                     r_err_valid;
   logic                     w_unused_ok;

   assign w_unused_ok = ^inst_sram_wdata;

   // Hit needs the window match and no offset bits above the array depth.
   assign w_inst_off = inst_sram_addr & MASK;
   assign w_data_off = data_sram_addr & MASK;
   assign w_inst_hit = ((inst_sram_addr & ~MASK) == BASE) && ((w_inst_off >> (AW + 2)) == 32'd0);
   assign w_data_hit = ((data_sram_addr & ~MASK) == BASE) && ((w_data_off >> (AW + 2)) == 32'd0);
   assign w_inst_idx = w_inst_off[AW+1:2];
   assign w_data_idx = w_data_off[AW+1:2];

   always_comb begin
      w_data_kind = ACC_IDLE;
      if (data_sram_en) begin
         if (!w_data_hit)               w_data_kind = ACC_BAD;
         else if (data_sram_wen != 4'd0) w_data_kind = ACC_WRITE;
         else                            w_data_kind = ACC_READ;
      end
   end

   assign w_we       = (w_data_kind == ACC_WRITE) ? data_sram_wen : 4'd0;
   assign w_data_err = (w_data_kind == ACC_BAD);
   assign w_inst_err = inst_sram_en && (!w_inst_hit || (inst_sram_wen != 4'd0));

   sram_bank_2r1w #(
      .AW (AW)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we),
      .i_waddr  (w_data_idx),
      .i_wdata  (data_sram_wdata),
      .i_a_load (inst_sram_en),
      .i_a_clr  (inst_sram_en && !w_inst_hit),
      .i_a_addr (w_inst_idx),
      .o_a_q    (inst_sram_rdata),
      .i_b_load (w_data_kind == ACC_READ),
      .i_b_clr  (w_data_err && (data_sram_wen == 4'd0)),
      .i_b_addr (w_data_idx),
      .o_b_q    (data_sram_rdata)
   );

   assign w_err_inc  = {1'b0, w_inst_err} + {1'b0, w_data_err};
   assign w_err_sum  = {1'b0, r_err_cnt} + {{(C_ERR_CNT_W-1){1'b0}}, w_err_inc};
   assign w_err_next = w_err_sum[C_ERR_CNT_W] ? C_ERR_CNT_MAX : w_err_sum[C_ERR_CNT_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt   <= '0;
         r_err_addr  <= '0;
         r_err_valid <= 1'b0;
      end else begin
         r_err_cnt <= w_err_next;
         if (!r_err_valid && (w_inst_err || w_data_err)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= w_data_err ? data_sram_addr : inst_sram_addr;
         end
      end
   end

   assign err_cnt   = r_err_cnt;
   assign err_addr  = r_err_addr;
   assign err_valid = r_err_valid;

endmodule

`default_nettype wire
